// File: rtl/lsu_mem_port_pkg.sv
// Shared types and constants for the LSU memory port.
package lsu_mem_port_pkg;

   // Default byte-address width of the data memory port.
   localparam int unsigned LSU_ADDR_W = 17;

   // RV32I load/store funct3 codes.
   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_ACC0 = 2'd1,
      LSU_ACC1 = 2'd2,
      LSU_DONE = 2'd3
   } lsu_state_e;

   // True for the five funct3 codes the port implements.
   function automatic logic lsu_f3_legal(input logic [2:0] f3);
      return (f3 == LSU_B) || (f3 == LSU_H) || (f3 == LSU_W) ||
             (f3 == LSU_BU) || (f3 == LSU_HU);
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store lane masks/data and load extract/extend.
module lsu_lane_align
   import lsu_mem_port_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [63:0] rdata,
   output logic [3:0]  we_lo,
   output logic [3:0]  we_hi,
   output logic [31:0] wdata_lo,
   output logic [31:0] wdata_hi,
   output logic        spans,
   output logic [31:0] load_data
);

   logic [7:0]  base_mask;
   logic [7:0]  lane_mask;
   logic [31:0] wdata_m;
   logic [63:0] wshift;
   logic [31:0] rshift;
   logic [4:0]  sh;

   // Position store bytes over an 8-lane (two-word) window and extract load bytes.
   always_comb begin
      base_mask = 8'h00;
      wdata_m   = 32'h0;
      load_data = 32'h0;
      sh        = {offset, 3'b000};

      // Size comes from funct3[1:0]; unused store bytes are zeroed so idle lanes carry 0.
      case (funct3[1:0])
         2'b00:   begin base_mask = 8'h01; wdata_m = {24'h0, wdata[7:0]};  end
         2'b01:   begin base_mask = 8'h03; wdata_m = {16'h0, wdata[15:0]}; end
         default: begin base_mask = 8'h0F; wdata_m = wdata;                end
      endcase

      lane_mask = base_mask << offset;
      we_lo     = lane_mask[3:0];
      we_hi     = lane_mask[7:4];
      // Any lane landing in 4..7 means size + offset > 4.
      spans     = |lane_mask[7:4];

      wshift    = {32'h0, wdata_m} << sh;
      wdata_lo  = wshift[31:0];
      wdata_hi  = wshift[63:32];

      rshift    = 32'(rdata >> sh);
      case (funct3)
         LSU_B:   load_data = {{24{rshift[7]}}, rshift[7:0]};
         LSU_H:   load_data = {{16{rshift[15]}}, rshift[15:0]};
         LSU_BU:  load_data = {24'h0, rshift[7:0]};
         LSU_HU:  load_data = {16'h0, rshift[15:0]};
         default: load_data = rshift;
      endcase
   end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator: one RV32I request becomes one or two word accesses.
module lsu_mem_port
   import lsu_mem_port_pkg::*;
#(
   parameter int unsigned ADDR_W = LSU_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_data,
   output logic              resp_err,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_r_addr,
   output logic [ADDR_W-1:0] mem_w_addr,
   output logic [31:0]       mem_w_data,
   input  logic [31:0]       mem_r_data
);

   localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

   lsu_state_e        state_q, state_d;
   logic              store_q, store_d;
   logic              err_q, err_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       lo_q, lo_d;
   logic [31:0]       hi_q, hi_d;

   logic [3:0]        we_lo, we_hi;
   logic [31:0]       wdata_lo, wdata_hi;
   logic              spans;
   logic [31:0]       load_data;
   logic [ADDR_W-1:0] word_addr, next_addr;

   // Address bits above the port width are deliberately dropped.
   logic unused_req_addr;
   assign unused_req_addr = ^req_addr[31:ADDR_W];

   assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
   assign next_addr = word_addr + WORD_STEP;  // wraps modulo 2^ADDR_W

   lsu_lane_align u_align (
      .funct3    (funct3_q),
      .offset    (addr_q[1:0]),
      .wdata     (wdata_q),
      .rdata     ({hi_q, lo_q}),
      .we_lo     (we_lo),
      .we_hi     (we_hi),
      .wdata_lo  (wdata_lo),
      .wdata_hi  (wdata_hi),
      .spans     (spans),
      .load_data (load_data)
   );

   // Next-state logic: request latch, read-data capture and sequencing.
   always_comb begin
      state_d  = state_q;
      store_d  = store_q;
      err_d    = err_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      lo_d     = lo_q;
      hi_d     = hi_q;

      unique case (state_q)
         LSU_IDLE: begin
            if (req_valid) begin
               store_d  = req_we;
               funct3_d = req_funct3;
               addr_d   = req_addr[ADDR_W-1:0];
               wdata_d  = req_wdata;
               lo_d     = 32'h0;
               hi_d     = 32'h0;
               err_d    = !lsu_f3_legal(req_funct3);
               state_d  = lsu_f3_legal(req_funct3) ? LSU_ACC0 : LSU_DONE;
            end
         end
         LSU_ACC0: begin
            if (!store_q) lo_d = mem_r_data;
            state_d = spans ? LSU_ACC1 : LSU_DONE;
         end
         LSU_ACC1: begin
            if (!store_q) hi_d = mem_r_data;
            state_d = LSU_DONE;
         end
         LSU_DONE: state_d = LSU_IDLE;
         default:  state_d = LSU_IDLE;
      endcase
   end

   // Outputs decoded from registered state only, so they settle before the falling edge.
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_data  = 32'h0;
      mem_we     = 4'h0;
      mem_r_addr = '0;
      mem_w_data = 32'h0;

      unique case (state_q)
         LSU_IDLE: req_ready = 1'b1;
         LSU_ACC0: begin
            mem_r_addr = word_addr;
            if (store_q) begin
               mem_we     = we_lo;
               mem_w_data = wdata_lo;
            end
         end
         LSU_ACC1: begin
            mem_r_addr = next_addr;
            if (store_q) begin
               mem_we     = we_hi;
               mem_w_data = wdata_hi;
            end
         end
         LSU_DONE: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            if (!err_q && !store_q) resp_data = load_data;
         end
         default: ;
      endcase
   end

   assign mem_w_addr = mem_r_addr;

   // State and request registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= LSU_IDLE;
         store_q  <= 1'b0;
         err_q    <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= '0;
         wdata_q  <= 32'h0;
         lo_q     <= 32'h0;
         hi_q     <= 32'h0;
      end else begin
         state_q  <= state_d;
         store_q  <= store_d;
         err_q    <= err_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
      end
   end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: byte-level reference model plus literal pins.
module tb_lsu_mem_port;

   localparam int MEM_BYTES = 131072;

   typedef struct packed {
      logic        ready;
      logic        rvalid;
      logic        err;
      logic [31:0] rdata;
      logic [3:0]  we;
      logic [16:0] addr;
      logic [31:0] wdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_err;
   logic [3:0]  mem_we;
   logic [16:0] mem_r_addr;
   logic [16:0] mem_w_addr;
   logic [31:0] mem_w_data;
   logic [31:0] mem_r_data;

   bit   [31:0] mem [0:32767];
   bit   [7:0]  ref_mem [0:MEM_BYTES-1];
   exp_t        exp_q[$];
   exp_t        exp_cur;
   exp_t        idle_rec;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          pres_cyc = 0;
   int          last_lat = -1;
   int          resp_cnt = 0;
   int          cnt_before;
   logic [31:0] last_data;
   logic        last_err;
   bit          chk_en = 1'b0;

   always #5 clk = ~clk;

   lsu_mem_port #(.ADDR_W(17)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .mem_we     (mem_we),
      .mem_r_addr (mem_r_addr),
      .mem_w_addr (mem_w_addr),
      .mem_w_data (mem_w_data),
      .mem_r_data (mem_r_data)
   );

   // Data memory: writes and read-data update on the falling edge.
   always @(negedge clk) begin
      logic [31:0] w;
      w = mem[mem_w_addr[16:2]];
      for (int l = 0; l < 4; l++)
         if (mem_we[l] === 1'b1) w[8*l +: 8] = mem_w_data[8*l +: 8];
      if (|mem_we === 1'b1) mem[mem_w_addr[16:2]] <= w;
      mem_r_data <= mem[mem_r_addr[16:2]];
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Per-cycle comparison of every DUT output against the model's expectation.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready",  {31'h0, req_ready},  {31'h0, exp_cur.ready});
         chk("resp_valid", {31'h0, resp_valid}, {31'h0, exp_cur.rvalid});
         chk("resp_err",   {31'h0, resp_err},   {31'h0, exp_cur.err});
         chk("resp_data",  resp_data,           exp_cur.rdata);
         chk("mem_we",     {28'h0, mem_we},     {28'h0, exp_cur.we});
         chk("mem_r_addr", {15'h0, mem_r_addr}, {15'h0, exp_cur.addr});
         chk("mem_w_addr", {15'h0, mem_w_addr}, {15'h0, exp_cur.addr});
         chk("mem_w_data", mem_w_data,          exp_cur.wdata);
         if (resp_valid === 1'b1) begin
            last_data = resp_data;
            last_err  = resp_err;
            last_lat  = cyc - pres_cyc;
            resp_cnt++;
         end
      end
   end

   // Byte-level model: list the cycles a request must produce, and update the reference memory.
   task automatic plan_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
      int s, a17, o, nw, lane;
      exp_t r;
      logic [31:0] ld;
      exp_q.delete();
      exp_q.push_back(idle_rec);
      case (f3)
         3'b000, 3'b100: s = 1;
         3'b001, 3'b101: s = 2;
         3'b010:         s = 4;
         default:        s = 0;
      endcase
      if (s == 0) begin
         r = '0; r.rvalid = 1'b1; r.err = 1'b1;
         exp_q.push_back(r);
         return;
      end
      a17 = int'(a & 32'h1FFFF);
      o   = a17 % 4;
      nw  = (o + s > 4) ? 2 : 1;
      for (int w = 0; w < nw; w++) begin
         r = '0;
         r.addr = 17'(((a17 - o) + 4 * w) % MEM_BYTES);
         if (st) begin
            for (int i = 0; i < s; i++) begin
               lane = o + i;
               if (lane / 4 == w) begin
                  r.we[lane % 4] = 1'b1;
                  r.wdata[8*(lane % 4) +: 8] = wd[8*i +: 8];
               end
            end
         end
         exp_q.push_back(r);
      end
      ld = 32'h0;
      for (int i = 0; i < s; i++) ld[8*i +: 8] = ref_mem[(a17 + i) % MEM_BYTES];
      if (f3 == 3'b000 && ld[7])  ld = ld | 32'hFFFFFF00;
      if (f3 == 3'b001 && ld[15]) ld = ld | 32'hFFFF0000;
      if (st) for (int i = 0; i < s; i++) ref_mem[(a17 + i) % MEM_BYTES] = wd[8*i +: 8];
      r = '0; r.rvalid = 1'b1; r.rdata = st ? 32'h0 : ld;
      exp_q.push_back(r);
   endtask

   // Present one request; junk requests are driven while busy and must be ignored.
   // abort_at > 0 raises rst during that cycle index of the plan.
   task automatic run_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int abort_at);
      int n;
      plan_req(st, f3, a, wd);
      n = exp_q.size();
      last_lat = -1;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
      pres_cyc = cyc;
      exp_cur = exp_q[0];
      for (int k = 1; k < n; k++) begin
         @(posedge clk); #1;
         if (abort_at > 0 && k > abort_at) begin
            rst = 1'b0; req_valid = 1'b0; exp_cur = idle_rec;
         end else begin
            req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
            req_addr = 32'h300; req_wdata = 32'hDEADDEAD;
            rst = (k == abort_at);
            exp_cur = exp_q[k];
         end
      end
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 1'b0; exp_cur = idle_rec;
   endtask

   initial begin
      idle_rec = '0;
      idle_rec.ready = 1'b1;
      exp_cur = idle_rec;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Aligned word store/load.
      run_req(1'b1, 3'b010, 32'h100, 32'h11223344, 0);
      chk("mem@100 after sw", mem[15'h40], 32'h11223344);
      run_req(1'b0, 3'b010, 32'h100, 32'h0, 0);
      chk("lw@100 data", last_data, 32'h11223344);
      chk("lw@100 latency", last_lat, 2);

      // Byte lane 3 with sign/zero extension.
      run_req(1'b1, 3'b000, 32'h103, 32'h000000A5, 0);
      chk("mem@100 after sb", mem[15'h40], 32'hA5223344);
      run_req(1'b0, 3'b000, 32'h103, 32'h0, 0);
      chk("lb@103 data", last_data, 32'hFFFFFFA5);
      run_req(1'b0, 3'b100, 32'h103, 32'h0, 0);
      chk("lbu@103 data", last_data, 32'h000000A5);

      // Halfword spanning two words.
      run_req(1'b1, 3'b001, 32'h103, 32'h0000BEEF, 0);
      chk("mem@100 after sh", mem[15'h40], 32'hEF223344);
      chk("mem@104 after sh", mem[15'h41], 32'h000000BE);
      run_req(1'b0, 3'b001, 32'h103, 32'h0, 0);
      chk("lh@103 data", last_data, 32'hFFFFBEEF);
      chk("lh@103 latency", last_lat, 3);

      // Top-of-memory wrap.
      run_req(1'b1, 3'b010, 32'h1FFFC, 32'hAABBCCDD, 0);
      run_req(1'b1, 3'b010, 32'h0, 32'h00001122, 0);
      run_req(1'b0, 3'b010, 32'h1FFFE, 32'h0, 0);
      chk("lw@1FFFE data", last_data, 32'h1122AABB);
      chk("lw@1FFFE latency", last_lat, 3);

      // Illegal funct3.
      run_req(1'b0, 3'b011, 32'h100, 32'h0, 0);
      chk("illegal ld latency", last_lat, 1);
      chk("illegal ld err", {31'h0, last_err}, 32'h1);
      chk("illegal ld data", last_data, 32'h0);
      run_req(1'b1, 3'b011, 32'h100, 32'hFFFFFFFF, 0);
      chk("illegal st err", {31'h0, last_err}, 32'h1);
      chk("mem@100 after illegal st", mem[15'h40], 32'hEF223344);
      run_req(1'b1, 3'b111, 32'h104, 32'hFFFFFFFF, 0);

      // Reset during ACC1 of a split store: both words land, no response.
      cnt_before = resp_cnt;
      run_req(1'b1, 3'b010, 32'h102, 32'hCAFEBABE, 2);
      chk("abort no resp", resp_cnt, cnt_before);
      chk("mem@100 after abort", mem[15'h40], 32'hBABE3344);
      chk("mem@104 after abort", mem[15'h41], 32'h0000CAFE);
      run_req(1'b0, 3'b010, 32'h100, 32'h0, 0);
      chk("lw@100 after abort", last_data, 32'hBABE3344);
      run_req(1'b0, 3'b010, 32'h200, 32'h0, 0);
      chk("lw@200 data", last_data, 32'h0);
      chk("lw@200 latency", last_lat, 2);

      // Further model-checked patterns.
      run_req(1'b0, 3'b101, 32'h101, 32'h0, 0);
      run_req(1'b1, 3'b001, 32'h102, 32'h00009234, 0);
      run_req(1'b0, 3'b001, 32'h102, 32'h0, 0);
      run_req(1'b0, 3'b101, 32'h102, 32'h0, 0);
      run_req(1'b0, 3'b010, 32'hFFFE0100, 32'h0, 0);
      run_req(1'b1, 3'b000, 32'h1FFFF, 32'h12345680, 0);
      run_req(1'b0, 3'b000, 32'h1FFFF, 32'h0, 0);
      chk("lb@1FFFF data", last_data, 32'hFFFFFF80);
      run_req(1'b0, 3'b101, 32'h1FFFF, 32'h0, 0);
      run_req(1'b1, 3'b010, 32'h207, 32'h89ABCDEF, 0);
      run_req(1'b0, 3'b010, 32'h207, 32'h0, 0);
      run_req(1'b0, 3'b100, 32'h208, 32'h0, 0);

      repeat (2) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
